// File: rtl/rob_superscalar.sv
// Multi-issue reorder buffer: in-order dispatch, out-of-order completion, in-order commit.
// Outputs are combinational from state (lookups add completion bypass); a full buffer refuses dispatch.
module rob_superscalar #(
  parameter int ROBsize = 32,
  parameter int DISP_W  = 2,
  parameter int CPL_W   = 2,
  parameter int CMT_W   = 2,
  parameter int RD_P    = 4,
  parameter int DEC_W   = 7,
  parameter int RES_W   = 65
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     flush_i,
  input  logic [DISP_W-1:0]                        dispValid_i,
  input  logic [DISP_W*DEC_W-1:0]                  dispData_i,
  output logic                                     dispReady_o,
  output logic [DISP_W*($clog2(ROBsize)+1)-1:0]    dispTag_o,
  input  logic [CPL_W-1:0]                         cplValid_i,
  input  logic [CPL_W*($clog2(ROBsize)+1)-1:0]     cplTag_i,
  input  logic [CPL_W*RES_W-1:0]                   cplData_i,
  input  logic [CPL_W-1:0]                         cplExc_i,
  input  logic [RD_P*($clog2(ROBsize)+1)-1:0]      rdTag_i,
  output logic [RD_P-1:0]                          rdDone_o,
  output logic [RD_P*RES_W-1:0]                    rdData_o,
  output logic [CMT_W-1:0]                         cmtValid_o,
  output logic [CMT_W*(DEC_W+RES_W)-1:0]           cmtData_o,
  output logic [CMT_W*($clog2(ROBsize)+1)-1:0]     cmtTag_o,
  output logic [CMT_W-1:0]                         cmtExc_o,
  input  logic                                     cmtReady_i,
  output logic [$clog2(ROBsize):0]                 count_o,
  output logic                                     empty_o
);
  localparam int AW = $clog2(ROBsize);
  localparam int TW = AW + 1;
  localparam int CW = DEC_W + RES_W;

  logic             valid_q [ROBsize];
  logic             valid_d [ROBsize];
  logic             done_q  [ROBsize];
  logic             done_d  [ROBsize];
  logic             exc_q   [ROBsize];
  logic             exc_d   [ROBsize];
  logic [DEC_W-1:0] dec_q   [ROBsize];
  logic [DEC_W-1:0] dec_d   [ROBsize];
  logic [RES_W-1:0] res_q   [ROBsize];
  logic [RES_W-1:0] res_d   [ROBsize];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [TW-1:0]    count_q, count_d;

  assign dispReady_o = (count_q <= TW'(ROBsize - DISP_W));
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);

  // Tags are 1-based so that tag 0 can mean "no entry".
  always_comb begin
    logic [AW-1:0] idx;
    logic          chain;
    logic          v;
    dispTag_o  = '0;
    cmtValid_o = '0;
    cmtExc_o   = '0;
    cmtData_o  = '0;
    cmtTag_o   = '0;
    chain      = 1'b1;
    for (int k = 0; k < DISP_W; k++) begin
      idx = tail_q + AW'(k);
      dispTag_o[k*TW +: TW] = {1'b0, idx} + TW'(1);
    end
    for (int k = 0; k < CMT_W; k++) begin
      idx = head_q + AW'(k);
      v   = chain && valid_q[idx] && done_q[idx] && (TW'(k) < count_q);
      cmtValid_o[k] = v;
      cmtExc_o[k]   = v && exc_q[idx];
      cmtData_o[k*CW +: CW] = {dec_q[idx], res_q[idx]};
      cmtTag_o[k*TW +: TW]  = {1'b0, idx} + TW'(1);
      chain = v && !exc_q[idx];
    end
  end

  always_comb begin
    logic [TW-1:0] t;
    logic [AW-1:0] idx;
    logic          hit;
    rdDone_o = '0;
    rdData_o = '0;
    for (int r = 0; r < RD_P; r++) begin
      t   = rdTag_i[r*TW +: TW];
      idx = AW'(t - TW'(1));
      hit = (t != '0) && (t <= TW'(ROBsize)) && valid_q[idx];
      if (hit && done_q[idx]) begin
        rdDone_o[r] = 1'b1;
        rdData_o[r*RES_W +: RES_W] = res_q[idx];
      end
      // Ascending scan lets the highest completion port win the bypass.
      for (int p = 0; p < CPL_W; p++) begin
        if (hit && cplValid_i[p] && (cplTag_i[p*TW +: TW] == t)) begin
          rdDone_o[r] = 1'b1;
          rdData_o[r*RES_W +: RES_W] = cplData_i[p*RES_W +: RES_W];
        end
      end
    end
  end

  always_comb begin
    logic [AW-1:0] idx;
    logic [TW-1:0] ct;
    logic [TW-1:0] disp_cnt;
    logic [TW-1:0] cmt_cnt;
    logic          exc_cmt;
    valid_d  = valid_q;
    done_d   = done_q;
    exc_d    = exc_q;
    dec_d    = dec_q;
    res_d    = res_q;
    disp_cnt = '0;
    cmt_cnt  = '0;
    for (int k = 0; k < DISP_W; k++)
      if (dispReady_o && dispValid_i[k]) disp_cnt = disp_cnt + TW'(1);
    for (int k = 0; k < CMT_W; k++)
      if (cmtReady_i && cmtValid_o[k]) cmt_cnt = cmt_cnt + TW'(1);
    exc_cmt = cmtReady_i && (|cmtExc_o);

    for (int p = 0; p < CPL_W; p++) begin
      ct  = cplTag_i[p*TW +: TW];
      idx = AW'(ct - TW'(1));
      if (cplValid_i[p] && (ct != '0) && (ct <= TW'(ROBsize)) && valid_q[idx]) begin
        done_d[idx] = 1'b1;
        exc_d[idx]  = cplExc_i[p];
        res_d[idx]  = cplData_i[p*RES_W +: RES_W];
      end
    end
    for (int k = 0; k < CMT_W; k++) begin
      idx = head_q + AW'(k);
      if (cmtReady_i && cmtValid_o[k]) begin
        valid_d[idx] = 1'b0;
        done_d[idx]  = 1'b0;
      end
    end
    // Dispatch slots are always free here, so they never collide with commits.
    for (int k = 0; k < DISP_W; k++) begin
      idx = tail_q + AW'(k);
      if (dispReady_o && dispValid_i[k]) begin
        valid_d[idx] = 1'b1;
        done_d[idx]  = 1'b0;
        exc_d[idx]   = 1'b0;
        dec_d[idx]   = dispData_i[k*DEC_W +: DEC_W];
      end
    end
    head_d  = head_q + cmt_cnt[AW-1:0];
    tail_d  = tail_q + disp_cnt[AW-1:0];
    count_d = count_q + disp_cnt - cmt_cnt;

    if (flush_i || exc_cmt) begin
      for (int i = 0; i < ROBsize; i++) begin
        valid_d[i] = 1'b0;
        done_d[i]  = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < ROBsize; i++) begin
        valid_q[i] <= 1'b0;
        done_q[i]  <= 1'b0;
        exc_q[i]   <= 1'b0;
        dec_q[i]   <= '0;
        res_q[i]   <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
      dec_q   <= dec_d;
      res_q   <= res_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_rob_superscalar.sv
// Bench for rob_superscalar: directed vector table, randomized traffic against an age-ordered queue model.
module tb_rob_superscalar;
  localparam int N = 8, DW = 2, PW = 2, CMW = 2, RP = 2, DECW = 7, RESW = 65, TW = 4;
  localparam int EW = DECW + RESW;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [DW-1:0]       disp_vld = '0;
  logic [DW*DECW-1:0]  disp_dat = '0;
  logic                disp_rdy;
  logic [DW*TW-1:0]    disp_tag;
  logic [PW-1:0]       cpl_vld = '0;
  logic [PW*TW-1:0]    cpl_tag = '0;
  logic [PW*RESW-1:0]  cpl_dat = '0;
  logic [PW-1:0]       cpl_exc = '0;
  logic [RP*TW-1:0]    rd_tag = '0;
  logic [RP-1:0]       rd_done;
  logic [RP*RESW-1:0]  rd_dat;
  logic [CMW-1:0]      cmt_vld;
  logic [CMW*EW-1:0]   cmt_dat;
  logic [CMW*TW-1:0]   cmt_tag;
  logic [CMW-1:0]      cmt_exc;
  logic                cmt_rdy = 1'b0;
  logic [TW-1:0]       count;
  logic                empty;

  always #5 clk = ~clk;

  rob_superscalar #(.ROBsize(N), .DISP_W(DW), .CPL_W(PW), .CMT_W(CMW), .RD_P(RP),
                    .DEC_W(DECW), .RES_W(RESW)) dut (
    .clk_i(clk), .reset_i(rst_n), .flush_i(flush),
    .dispValid_i(disp_vld), .dispData_i(disp_dat), .dispReady_o(disp_rdy), .dispTag_o(disp_tag),
    .cplValid_i(cpl_vld), .cplTag_i(cpl_tag), .cplData_i(cpl_dat), .cplExc_i(cpl_exc),
    .rdTag_i(rd_tag), .rdDone_o(rd_done), .rdData_o(rd_dat),
    .cmtValid_o(cmt_vld), .cmtData_o(cmt_dat), .cmtTag_o(cmt_tag), .cmtExc_o(cmt_exc),
    .cmtReady_i(cmt_rdy), .count_o(count), .empty_o(empty)
  );

  typedef struct {
    int              tag;
    bit              done;
    bit              exc;
    logic [DECW-1:0] dec;
    logic [RESW-1:0] res;
  } ent_t;

  ent_t mq[$];
  int   next_tag = 1;
  int   checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_find(input logic [TW-1:0] t);
    for (int i = 0; i < mq.size(); i++) if (mq[i].tag == int'(t)) return i;
    return -1;
  endfunction

  // Oldest entries retire while done; an exception entry is the last to go.
  function automatic int m_ncmt();
    int n = 0;
    for (int k = 0; k < CMW; k++) begin
      if (k >= mq.size() || !mq[k].done) break;
      n++;
      if (mq[k].exc) break;
    end
    return n;
  endfunction

  task automatic check_all();
    int n, i;
    bit ev, ed;
    logic [RESW-1:0] edat;
    logic [TW-1:0] t;
    n = m_ncmt();
    chk("disp_rdy", disp_rdy, mq.size() <= N - DW);
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    for (int k = 0; k < DW; k++) chk("disp_tag", disp_tag[k*TW +: TW], ((next_tag - 1 + k) % N) + 1);
    for (int k = 0; k < CMW; k++) begin
      ev = (k < n);
      chk("cmt_vld", cmt_vld[k], ev);
      chk("cmt_exc", cmt_exc[k], ev ? mq[k].exc : 1'b0);
      if (ev) begin
        chk("cmt_tag", cmt_tag[k*TW +: TW], mq[k].tag);
        chk("cmt_dat", cmt_dat[k*EW +: EW], {mq[k].dec, mq[k].res});
      end
    end
    for (int r = 0; r < RP; r++) begin
      t = rd_tag[r*TW +: TW];
      i = m_find(t);
      ed = 1'b0;
      edat = '0;
      if (i >= 0) begin
        ed = mq[i].done;
        edat = mq[i].res;
        for (int p = 0; p < PW; p++)
          if (cpl_vld[p] && cpl_tag[p*TW +: TW] == t) begin
            ed = 1'b1;
            edat = cpl_dat[p*RESW +: RESW];
          end
      end
      chk("rd_done", rd_done[r], ed);
      if (ed) chk("rd_dat", rd_dat[r*RESW +: RESW], edat);
    end
  endtask

  task automatic m_step();
    int n, i;
    bit rdy, xflush;
    rdy = (mq.size() <= N - DW);
    n = cmt_rdy ? m_ncmt() : 0;
    xflush = (n > 0) && mq[n-1].exc;
    if (flush || xflush) begin
      mq.delete();
      next_tag = 1;
      return;
    end
    for (int p = 0; p < PW; p++) begin
      i = m_find(cpl_tag[p*TW +: TW]);
      if (cpl_vld[p] && i >= 0) begin
        mq[i].done = 1'b1;
        mq[i].exc = cpl_exc[p];
        mq[i].res = cpl_dat[p*RESW +: RESW];
      end
    end
    repeat (n) void'(mq.pop_front());
    if (rdy)
      for (int k = 0; k < DW; k++)
        if (disp_vld[k]) begin
          mq.push_back('{tag: next_tag, done: 1'b0, exc: 1'b0, dec: disp_dat[k*DECW +: DECW], res: '0});
          next_tag = next_tag % N + 1;
        end
  endtask

  task automatic cycle();
    #2;
    check_all();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  function automatic logic [RESW-1:0] rnd65();
    return {1'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  task automatic idle();
    disp_vld = '0; cpl_vld = '0; cpl_exc = '0; cmt_rdy = 1'b0; flush = 1'b0; rd_tag = '0;
  endtask

  typedef struct {
    logic [1:0] dv, cv;
    logic [3:0] ct0, ct1;
    logic [1:0] ce;
    logic       cr, fl;
    logic [3:0] rt;
    logic [3:0] e_cnt;
    logic       e_rdy;
    logic [1:0] e_cv, e_ce;
    logic       e_rd;
    logic [3:0] e_dt;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] dv, cv, input logic [3:0] ct0, ct1,
                              input logic [1:0] ce, input logic cr, fl, input logic [3:0] rt,
                              input logic [3:0] e_cnt, input logic e_rdy, input logic [1:0] e_cv, e_ce,
                              input logic e_rd, input logic [3:0] e_dt);
    return '{dv, cv, ct0, ct1, ce, cr, fl, rt, e_cnt, e_rdy, e_cv, e_ce, e_rd, e_dt};
  endfunction

  initial begin
    vec_t tbl[18];
    //          dv cv ct0 ct1 ce cr fl rt | cnt rdy cv ce rd dt
    tbl[0]  = mk(3, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1);
    tbl[1]  = mk(3, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0, 3);
    tbl[2]  = mk(3, 0, 0, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0, 5);
    tbl[3]  = mk(3, 0, 0, 0, 0, 0, 0, 0,   6, 1, 0, 0, 0, 7);
    tbl[4]  = mk(3, 0, 0, 0, 0, 0, 0, 0,   8, 0, 0, 0, 0, 1);
    tbl[5]  = mk(0, 1, 2, 0, 0, 0, 0, 2,   8, 0, 0, 0, 1, 1);
    tbl[6]  = mk(0, 1, 1, 0, 0, 0, 0, 2,   8, 0, 0, 0, 1, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 0, 1,   8, 0, 3, 0, 1, 1);
    tbl[8]  = mk(0, 3, 3, 4, 0, 0, 0, 0,   6, 1, 0, 0, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 3,   6, 1, 3, 0, 1, 1);
    tbl[10] = mk(3, 0, 0, 0, 0, 0, 0, 1,   4, 1, 0, 0, 0, 1);
    tbl[11] = mk(0, 3, 5, 6, 1, 0, 0, 1,   6, 1, 0, 0, 0, 3);
    tbl[12] = mk(0, 0, 0, 0, 0, 1, 0, 6,   6, 1, 1, 1, 1, 3);
    tbl[13] = mk(3, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1);
    tbl[14] = mk(3, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0, 3);
    tbl[15] = mk(0, 3, 3, 1, 0, 0, 0, 3,   4, 1, 0, 0, 1, 5);
    tbl[16] = mk(3, 1, 2, 0, 0, 0, 1, 1,   4, 1, 1, 0, 1, 5);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1);

    // Reset state while reset is held.
    idle();
    rd_tag = {4'd2, 4'd1};
    #3;
    chk("rst_rdy", disp_rdy, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_count", count, 4'd0);
    chk("rst_cmt_vld", cmt_vld, 2'b00);
    chk("rst_cmt_exc", cmt_exc, 2'b00);
    chk("rst_rd_done", rd_done, 2'b00);
    chk("rst_disp_tag", disp_tag, {4'd2, 4'd1});
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    foreach (tbl[i]) begin
      disp_vld = tbl[i].dv;
      disp_dat = DW*DECW'($urandom);
      cpl_vld  = tbl[i].cv;
      cpl_tag  = {tbl[i].ct1, tbl[i].ct0};
      cpl_dat  = {rnd65(), rnd65()};
      cpl_exc  = tbl[i].ce;
      cmt_rdy  = tbl[i].cr;
      flush    = tbl[i].fl;
      rd_tag   = {4'd0, tbl[i].rt};
      #1;
      chk("tbl_count", count, tbl[i].e_cnt);
      chk("tbl_rdy", disp_rdy, tbl[i].e_rdy);
      chk("tbl_cmt_vld", cmt_vld, tbl[i].e_cv);
      chk("tbl_cmt_exc", cmt_exc, tbl[i].e_ce);
      chk("tbl_rd_done", rd_done[0], tbl[i].e_rd);
      chk("tbl_disp_tag", disp_tag[TW-1:0], tbl[i].e_dt);
      cycle();
    end

    // Randomized traffic, checked every cycle against the queue model.
    repeat (600) begin
      int r;
      r = $urandom_range(2, 0);
      disp_vld = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      disp_dat = DW*DECW'($urandom);
      for (int p = 0; p < PW; p++) begin
        cpl_vld[p] = 1'($urandom);
        if (mq.size() > 0 && $urandom_range(3, 0) != 0)
          cpl_tag[p*TW +: TW] = 4'(mq[$urandom_range(mq.size() - 1, 0)].tag);
        else
          cpl_tag[p*TW +: TW] = 4'($urandom_range(N, 0));
        cpl_exc[p] = ($urandom_range(15, 0) == 0);
        cpl_dat[p*RESW +: RESW] = rnd65();
      end
      cmt_rdy = ($urandom_range(3, 0) != 0);
      flush   = ($urandom_range(39, 0) == 0);
      for (int q = 0; q < RP; q++) rd_tag[q*TW +: TW] = 4'($urandom_range(N, 0));
      cycle();
    end

    // Fill to five entries, then assert reset between clock edges.
    idle(); flush = 1'b1; cycle();
    idle(); disp_vld = 2'b11; disp_dat = 14'h1abc; cycle();
    idle(); disp_vld = 2'b11; disp_dat = 14'h0f0f; cycle();
    idle(); disp_vld = 2'b01; disp_dat = 14'h0123;
    cpl_vld = 2'b01; cpl_tag = {4'd0, 4'd1}; cpl_dat = {rnd65(), rnd65()};
    cycle();
    idle();
    rd_tag = {4'd2, 4'd1};
    #1;
    check_all();
    chk("pre_rst_count", count, 4'd5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rdy", disp_rdy, 1'b1);
    chk("async_empty", empty, 1'b1);
    chk("async_count", count, 4'd0);
    chk("async_cmt_vld", cmt_vld, 2'b00);
    chk("async_cmt_exc", cmt_exc, 2'b00);
    chk("async_rd_done", rd_done, 2'b00);
    chk("async_disp_tag", disp_tag, {4'd2, 4'd1});
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    next_tag = 1;
    disp_vld = 2'b11;
    cycle();
    idle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
